// File: rtl/multi_clock_divider.sv
// Multi-channel speed-to-clock divider. A single shared restoring divider turns each channel's
// speed into a period length round-robin; per-channel counters swap periods only at boundaries.
module multi_clock_divider #(
  parameter int unsigned MAX_SPEED = 50000000,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] speed,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clk_div,
  output logic [CHANNELS-1:0]       tick
);

  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] Dividend = WIDTH'(MAX_SPEED);
  localparam logic [WIDTH-1:0] MinDiv   = WIDTH'(2);

  typedef enum logic [1:0] {StLoad, StDiv, StWrite} state_e;

  state_e           state_q, state_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] dsor_q, dsor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the dividend; quotient bits shift in from the bottom as dividend bits leave the top.
  logic [WIDTH-1:0] quo_q, quo_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] speed_sel;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;

  logic [WIDTH-1:0] pend_q  [CHANNELS];
  logic [WIDTH-1:0] pend_d  [CHANNELS];
  logic [WIDTH-1:0] div_q   [CHANNELS];
  logic [WIDTH-1:0] div_d   [CHANNELS];
  logic [WIDTH-1:0] count_q [CHANNELS];
  logic [WIDTH-1:0] count_d [CHANNELS];
  logic [CHANNELS-1:0] at_end;
  logic [CHANNELS-1:0] clk_div_d;
  logic [CHANNELS-1:0] tick_d;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  // Only used when rem_shift >= dsor, where the difference always fits in WIDTH bits.
  assign rem_sub   = rem_shift[WIDTH-1:0] - dsor_q;

  always_comb begin
    speed_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == ChW'(i)) speed_sel = speed[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    dsor_d  = dsor_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    wr_en   = 1'b0;
    wr_val  = '0;
    unique case (state_q)
      StLoad: begin
        dsor_d  = speed_sel;
        rem_d   = '0;
        quo_d   = Dividend;
        bit_d   = '0;
        state_d = StDiv;
      end
      StDiv: begin
        if (rem_shift >= {1'b0, dsor_q}) begin
          rem_d = rem_sub;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        bit_d = bit_q + 1'b1;
        if (bit_q == BitW'(WIDTH - 1)) state_d = StWrite;
      end
      StWrite: begin
        wr_en = 1'b1;
        if (dsor_q == '0) begin
          wr_val = '0;
        end else if (quo_q < MinDiv) begin
          wr_val = MinDiv;
        end else begin
          wr_val = quo_q;
        end
        ch_d    = (ch_q == ChW'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pend_d[i] = pend_q[i];
      if (wr_en && (ch_q == ChW'(i))) pend_d[i] = wr_val;

      at_end[i]  = (div_q[i] != '0) && (count_q[i] >= div_q[i] - 1'b1);
      div_d[i]   = div_q[i];
      count_d[i] = count_q[i] + 1'b1;
      // Every non-counting case also reloads the divisor, so new periods only land here.
      if (sync || !enable[i] || (div_q[i] == '0) || at_end[i]) begin
        count_d[i] = '0;
        div_d[i]   = pend_q[i];
      end

      clk_div_d[i] = enable[i] && (div_q[i] != '0) && (count_q[i] < (div_q[i] >> 1));
      tick_d[i]    = enable[i] && at_end[i] && !sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      ch_q    <= '0;
      bit_q   <= '0;
      dsor_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      clk_div <= '0;
      tick    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_q[i]  <= '0;
        div_q[i]   <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      bit_q   <= bit_d;
      dsor_q  <= dsor_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      clk_div <= clk_div_d;
      tick    <= tick_d;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_q[i]  <= pend_d[i];
        div_q[i]   <= div_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: cycle scoreboard against a behavioural model plus directed
// period/phase measurements for each scenario.
module tb_multi_clock_divider;

  localparam int unsigned MaxSpeed = 100;
  localparam int unsigned Channels = 2;
  localparam int unsigned Width    = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [Channels*Width-1:0] speed;
  logic [Channels-1:0]       enable;
  logic                      sync;
  logic [Channels-1:0]       clk_div;
  logic [Channels-1:0]       tick;

  always #5 clk = ~clk;

  multi_clock_divider #(
    .MAX_SPEED(MaxSpeed),
    .CHANNELS (Channels),
    .WIDTH    (Width)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .speed  (speed),
    .enable (enable),
    .sync   (sync),
    .clk_div(clk_div),
    .tick   (tick)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: engine as a phase counter, divisor by direct integer division.
  typedef struct packed {
    logic [Channels-1:0] cd;
    logic [Channels-1:0] tk;
  } exp_t;

  exp_t exp_q[$];
  int   m_phase, m_ch, m_lat;
  int   m_pend [Channels];
  int   m_div  [Channels];
  int   m_count[Channels];

  function automatic int quotient(input int s);
    int q;
    if (s == 0) return 0;
    q = MaxSpeed / s;
    return (q < 2) ? 2 : q;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    if (!rst) begin
      for (int i = 0; i < Channels; i++) begin
        e.cd[i] = enable[i] && (m_div[i] != 0) && (m_count[i] < m_div[i] / 2);
        e.tk[i] = enable[i] && (m_div[i] != 0) && (m_count[i] >= m_div[i] - 1) && !sync;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_q.push_back(predict());
    if (rst) begin
      m_phase <= 0;
      m_ch    <= 0;
      for (int i = 0; i < Channels; i++) begin
        m_pend[i]  <= 0;
        m_div[i]   <= 0;
        m_count[i] <= 0;
      end
    end else begin
      if (m_phase == 0) begin
        m_lat   <= int'(speed[m_ch*Width +: Width]);
        m_phase <= 1;
      end else if (m_phase <= Width) begin
        m_phase <= m_phase + 1;
      end else begin
        m_pend[m_ch] <= quotient(m_lat);
        m_ch         <= (m_ch + 1) % Channels;
        m_phase      <= 0;
      end
      for (int i = 0; i < Channels; i++) begin
        if (sync || !enable[i] || m_div[i] == 0 || m_count[i] >= m_div[i] - 1) begin
          m_count[i] <= 0;
          m_div[i]   <= m_pend[i];
        end else begin
          m_count[i] <= m_count[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check_eq("sb_clk_div", 32'(clk_div), 32'(exp_q[0].cd));
      check_eq("sb_tick", 32'(tick), 32'(exp_q[0].tk));
      void'(exp_q.pop_front());
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(input int ch, input int n, output int highs, output int ticks);
    highs = 0;
    ticks = 0;
    repeat (n) begin
      @(negedge clk);
      if (clk_div[ch]) highs++;
      if (tick[ch]) ticks++;
    end
  endtask

  task automatic set_speed(input int ch, input int s);
    speed[ch*Width +: Width] = Width'(s);
  endtask

  int  highs, ticks, run, busy;
  bit  found;

  initial begin
    rst    = 1'b1;
    speed  = '0;
    enable = 2'b01;
    sync   = 1'b0;
    set_speed(0, 10);
    cycles(3);
    check_eq("reset_clk_div", 32'(clk_div), 32'h0);
    check_eq("reset_tick", 32'(tick), 32'h0);
    rst = 1'b0;

    // First output appears only after the first WRITE and the reload that follows.
    measure(0, 11, highs, ticks);
    check_eq("first_quiet_highs", highs, 0);
    check_eq("first_quiet_ticks", ticks, 0);
    measure(0, 40, highs, ticks);
    check_eq("ch0_div10_highs", highs, 20);
    check_eq("ch0_div10_ticks", ticks, 4);

    // Odd divisor on channel 1, channel 0 untouched.
    set_speed(1, 33);
    enable = 2'b11;
    cycles(60);
    measure(1, 30, highs, ticks);
    check_eq("ch1_div3_highs", highs, 10);
    check_eq("ch1_div3_ticks", ticks, 10);
    measure(0, 30, highs, ticks);
    check_eq("ch0_indep_highs", highs, 15);
    check_eq("ch0_indep_ticks", ticks, 3);

    // Mid-period change 10 -> 20; the scoreboard covers the exact transition.
    cycles(3);
    set_speed(0, 20);
    cycles(50);
    measure(0, 60, highs, ticks);
    check_eq("ch0_div5_highs", highs, 24);
    check_eq("ch0_div5_ticks", ticks, 12);

    // Stop, clamp, resume.
    set_speed(0, 0);
    cycles(50);
    measure(0, 30, highs, ticks);
    check_eq("stop_highs", highs, 0);
    check_eq("stop_ticks", ticks, 0);
    set_speed(0, 200);
    cycles(50);
    measure(0, 30, highs, ticks);
    check_eq("clamp_highs", highs, 15);
    check_eq("clamp_ticks", ticks, 15);
    set_speed(0, 10);
    cycles(50);
    measure(0, 30, highs, ticks);
    check_eq("resume_highs", highs, 15);
    check_eq("resume_ticks", ticks, 3);

    // Drop enable during a high phase.
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (clk_div[0]) found = 1'b1;
    end
    check_eq("wait_ch0_high", 32'(found), 32'h1);
    enable[0] = 1'b0;
    @(negedge clk);
    check_eq("disable_low", 32'(clk_div[0]), 32'h0);
    cycles(3);
    enable[0] = 1'b1;
    run = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (clk_div[0]) run++;
      else if (run > 0) break;
    end
    check_eq("reenable_high_run", run, 5);

    // Sync realigns both channels.
    cycles(7);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    @(negedge clk);
    check_eq("sync_in_phase", 32'(clk_div), 32'h3);

    // Reset while the engine is dividing for channel 1.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (m_ch == 1 && m_phase >= 2 && m_phase <= Width) found = 1'b1;
    end
    check_eq("wait_ch1_div", 32'(found), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_clk_div", 32'(clk_div), 32'h0);
    check_eq("midrst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    busy = 0;
    repeat (11) begin
      @(negedge clk);
      if (clk_div != '0 || tick != '0) busy++;
    end
    check_eq("midrst_quiet", busy, 0);
    @(negedge clk);
    check_eq("midrst_ch0_first", 32'(clk_div), 32'h1);

    cycles(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised multi-channel successor to the single-channel speed-to-clock divider. Each of `CHANNELS` independent outputs runs at roughly `MAX_SPEED / speed` of the system clock. One shared sequential restoring divider computes all divisors round-robin, so no combinational divide exists. New divisors take effect only at a period boundary (glitch-free). Per-channel enable, a global phase-sync input and one-cycle tick outputs are provided. It drives the slot-machine reel/blink timing from one block.

## Interface
- `MAX_SPEED`, 50000000: system clock frequency in Hz; must satisfy `MAX_SPEED < 2**WIDTH`.
- `CHANNELS`, 4: number of independent divided outputs, ≥1.
- `WIDTH`, 26: width of speed, divisor and counter fields.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `speed`  in  CHANNELS*WIDTH  channel i speed in bits `[i*WIDTH +: WIDTH]`; unsigned.
- `enable`  in  CHANNELS  per-channel run enable.
- `sync`  in  1  one-cycle pulse; phase-aligns all channels.
- `clk_div`  out  CHANNELS  divided clocks, registered.
- `tick`  out  CHANNELS  one-cycle pulse per completed period, registered.

## Operation
- Divider engine FSM, states LOAD → DIV → WRITE → LOAD:
  - LOAD, 1 cycle: latch `speed` of channel `ch`, clear remainder, load dividend `MAX_SPEED`.
  - DIV, exactly `WIDTH` cycles: one restoring quotient bit per cycle, MSB first.
  - WRITE, 1 cycle: write result to `pend[ch]`; `ch` increments, wrapping `CHANNELS-1` → 0.
  - If latched speed == 0: DIV still runs its full `WIDTH` cycles; WRITE stores 0, meaning stopped.
  - If speed ≠ 0 and quotient < 2: store 2.
  - A speed change during DIV is ignored until that channel's next LOAD.
- Per-channel registers: `pend` (WIDTH), `div` (WIDTH), `count` (WIDTH).
- Per-channel counter, in priority order:
  1. `rst`: clear `count`, `div` and `pend`.
  2. `sync`: `count` ← 0 and `div` ← `pend`.
  3. `enable` low: `count` held at 0; `div` ← `pend` each cycle.
  4. `div` == 0: `count` held at 0; `div` ← `pend`.
  5. `count` ≥ `div`-1: `count` ← 0 and `div` ← `pend`. This is the period boundary.
  6. Otherwise: `count` ← `count`+1.
- Output registers: `clk_div[i]` ← `enable[i]` && `div` ≠ 0 && `count` < `div`/2, using floor division. For odd `div`, the high phase is one cycle shorter than the low phase.
- `tick[i]` ← `enable[i]` && `div` ≠ 0 && `count` ≥ `div`-1 && !`sync`.
- Rising `enable` always starts a period at `count` 0, so the high phase comes first.

## Timing
- Reset values: `clk_div` = 0, `tick` = 0, all `count`/`div`/`pend` = 0. The FSM enters LOAD with `ch` = 0 on the first cycle after `rst` deasserts.
- Engine period per channel: `WIDTH`+2 cycles. Full refresh: `CHANNELS*(WIDTH+2)` cycles.
- Speed-to-`pend` worst-case latency: `CHANNELS*(WIDTH+2)` + `WIDTH`+2 cycles.
- `pend`-to-`div` latency: up to one old period. It is immediate if the channel is stopped or disabled.
- Outputs lag `count` by one cycle.
- `tick[i]` is high for exactly 1 cycle per period, aligned with the final low cycle of `clk_div[i]`'s period.
- `rst` in mid-DIV: the quotient is discarded and the engine restarts at channel 0.
- `sync` coinciding with a boundary: a single reload occurs and no tick is emitted.

## Test plan
Bench parameters for all scenarios: `MAX_SPEED`=100, `WIDTH`=8, `CHANNELS`=2.
- Reset/first output: `rst` for 3 cycles, speed0=10, enable0=1.
  - `clk_div` and `tick` stay 0 until the first WRITE, 10 cycles after reset release.
  - After that, `clk_div[0]` is high 5 / low 5, and `tick[0]` pulses every 10 cycles.
- Odd divisor and channel independence: speed0=10, speed1=33 (quotient 3), both enabled.
  - Channel 1 is high 1 / low 2 with ticks every 3 cycles.
  - Channel 0 is unaffected.
- Glitch-free change: speed0 moves 10→20 mid-period.
  - The current 10-cycle period completes intact.
  - The next period is 5 cycles (high 2 / low 3).
  - No short pulse appears at the transition.
- Stop and clamp:
  - speed0=0: `clk_div[0]` goes 0 and stays 0, with no ticks.
  - speed0=200 (quotient 0): period is 2, high 1 / low 1.
  - Restoring speed0=10 resumes the 10-cycle period from `count` 0.
- Enable and sync: drop enable0 mid-high-phase.
  - Next cycle `clk_div[0]` = 0.
  - Re-enabling starts a high phase of 5 cycles.
  - A `sync` pulse with channels at different phases makes both `clk_div` go high on the cycle after next, in phase.
- Reset mid-DIV: assert `rst` during channel 1 DIV.
  - All outputs read 0 the cycle after.
  - Channel 0 is recomputed first after release.
